// File: rtl/voice_alloc_pkg.sv
// Shared types and constants for the polyphonic voice allocator.
package voice_alloc_pkg;

  localparam int unsigned NOTE_BITS     = 7;
  localparam int unsigned FREQ_RES_BITS = 8;
  localparam int unsigned VOLUME_BITS   = 8;
  localparam int unsigned CNT_BITS      = 16;

  localparam logic [CNT_BITS-1:0] CNT_SAT = 16'hFFFF;

  typedef enum logic [1:0] {FREE, ACTIVE, RELEASING} voice_state_t;
  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} ctrl_state_t;

  typedef struct packed {
    logic                     on;
    logic [NOTE_BITS-1:0]     key;
    logic [FREQ_RES_BITS-1:0] freq;
    logic [VOLUME_BITS-1:0]   vol;
  } req_t;

  // Saturating increment for the statistics counters.
  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (v == CNT_SAT) ? v : v + CNT_BITS'(1);
  endfunction

endpackage

// File: rtl/voice_allocator_if.sv
// Note request handshake between the keyboard front end and the allocator.
interface voice_allocator_if;
  import voice_alloc_pkg::*;

  logic                     req_valid;
  logic                     req_ready;
  logic                     req_on;
  logic [NOTE_BITS-1:0]     req_key;
  logic [FREQ_RES_BITS-1:0] req_freq;
  logic [VOLUME_BITS-1:0]   req_vol;

  modport master (output req_valid, req_on, req_key, req_freq, req_vol, input req_ready);
  modport slave  (input req_valid, req_on, req_key, req_freq, req_vol, output req_ready);
endinterface

// File: rtl/voice_slot.sv
// One voice: state, key, freq, vol, age and release timer.
module voice_slot
  import voice_alloc_pkg::*;
#(
  parameter int unsigned RELEASE_CYCLES = 65536,
  parameter int unsigned AGE_BITS       = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_i,
  input  logic                     release_i,
  input  logic                     age_tick_i,
  input  logic [NOTE_BITS-1:0]     key_i,
  input  logic [FREQ_RES_BITS-1:0] freq_i,
  input  logic [VOLUME_BITS-1:0]   vol_i,
  output voice_state_t             state_o,
  output logic [NOTE_BITS-1:0]     key_o,
  output logic [FREQ_RES_BITS-1:0] freq_o,
  output logic [VOLUME_BITS-1:0]   vol_o,
  output logic [AGE_BITS-1:0]      age_o
);

  localparam int unsigned REL_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
  localparam logic [REL_W-1:0] REL_INIT = REL_W'(RELEASE_CYCLES - 1);

  voice_state_t             state_q, state_d;
  logic [NOTE_BITS-1:0]     key_q, key_d;
  logic [FREQ_RES_BITS-1:0] freq_q, freq_d;
  logic [VOLUME_BITS-1:0]   vol_q, vol_d;
  logic [AGE_BITS-1:0]      age_q, age_d;
  logic [REL_W-1:0]         rel_q, rel_d;

  // Next state: expiry first, then controller commands (load overrides all).
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    freq_d  = freq_q;
    vol_d   = vol_q;
    age_d   = age_q;
    rel_d   = rel_q;
    if (state_q == RELEASING) begin
      if (rel_q == '0) begin
        state_d = FREE;
        vol_d   = '0;
      end else begin
        rel_d = rel_q - REL_W'(1);
      end
    end
    if (age_tick_i && (state_q != FREE) && (age_q != '1)) begin
      age_d = age_q + AGE_BITS'(1);
    end
    if (release_i) begin
      state_d = RELEASING;
      rel_d   = REL_INIT;
    end
    if (load_i) begin
      state_d = ACTIVE;
      key_d   = key_i;
      freq_d  = freq_i;
      vol_d   = vol_i;
      age_d   = '0;
      rel_d   = '0;
    end
  end

  // Voice state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FREE;
      key_q   <= '0;
      freq_q  <= '0;
      vol_q   <= '0;
      age_q   <= '0;
      rel_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      freq_q  <= freq_d;
      vol_q   <= vol_d;
      age_q   <= age_d;
      rel_q   <= rel_d;
    end
  end

  assign state_o = state_q;
  assign key_o   = key_q;
  assign freq_o  = freq_q;
  assign vol_o   = vol_q;
  assign age_o   = age_q;

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: IDLE/SCAN/COMMIT controller over NUM_VOICES slots.
// Optional statistics counters enabled by VOICE_ALLOCATOR_STATS_EN.
module voice_allocator
  import voice_alloc_pkg::*;
#(
  parameter int unsigned NUM_VOICES     = 4,
  parameter int unsigned RELEASE_CYCLES = 65536,
  parameter int unsigned AGE_BITS       = 8
) (
  input  logic                                mclk,
  input  logic                                rst_n,
  voice_allocator_if.slave                    req,
  output logic [NUM_VOICES*FREQ_RES_BITS-1:0] voice_freq,
  output logic [NUM_VOICES*VOLUME_BITS-1:0]   voice_vol,
  output logic [NUM_VOICES-1:0]               voice_gate,
  output logic [NUM_VOICES-1:0]               voice_busy,
  output logic                                steal_pulse,
  output logic [CNT_BITS-1:0]                 steal_count,
  output logic [CNT_BITS-1:0]                 drop_count
);

  localparam int unsigned IDX_W = $clog2(NUM_VOICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  ctrl_state_t         state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  req_t                req_q, req_d;
  logic                match_found_q, match_found_d;
  logic [IDX_W-1:0]    match_idx_q, match_idx_d;
  logic                free_found_q, free_found_d;
  logic [IDX_W-1:0]    free_idx_q, free_idx_d;
  logic                cand_valid_q, cand_valid_d;
  logic                cand_rel_q, cand_rel_d;
  logic [IDX_W-1:0]    cand_idx_q, cand_idx_d;
  logic [AGE_BITS-1:0] cand_age_q, cand_age_d;
  logic                steal_pulse_q, steal_d;

  logic [NUM_VOICES-1:0] load_vec, release_vec;
  logic                  age_tick;
  logic [IDX_W-1:0]      target;

  voice_state_t             slot_state [NUM_VOICES];
  logic [NOTE_BITS-1:0]     slot_key   [NUM_VOICES];
  logic [FREQ_RES_BITS-1:0] slot_freq  [NUM_VOICES];
  logic [VOLUME_BITS-1:0]   slot_vol   [NUM_VOICES];
  logic [AGE_BITS-1:0]      slot_age   [NUM_VOICES];

  voice_state_t        cur_state;
  logic                cur_busy, cur_rel, cur_key_hit, better;
  logic [AGE_BITS-1:0] cur_age;

  assign cur_state   = slot_state[idx_q];
  assign cur_age     = slot_age[idx_q];
  assign cur_busy    = (cur_state != FREE);
  assign cur_rel     = (cur_state == RELEASING);
  assign cur_key_hit = (slot_key[idx_q] == req_q.key) &&
                       (req_q.on ? cur_busy : (cur_state == ACTIVE));
  assign better      = !cand_valid_q || (cur_rel && !cand_rel_q) ||
                       ((cur_rel == cand_rel_q) && (cur_age > cand_age_q));

  // Controller next state, scan bookkeeping and commit commands.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    req_d         = req_q;
    match_found_d = match_found_q;
    match_idx_d   = match_idx_q;
    free_found_d  = free_found_q;
    free_idx_d    = free_idx_q;
    cand_valid_d  = cand_valid_q;
    cand_rel_d    = cand_rel_q;
    cand_idx_d    = cand_idx_q;
    cand_age_d    = cand_age_q;
    steal_d       = 1'b0;
    load_vec      = '0;
    release_vec   = '0;
    age_tick      = 1'b0;
    target        = '0;
    case (state_q)
      IDLE: begin
        if (req.req_valid) begin
          req_d.on      = req.req_on;
          req_d.key     = req.req_key;
          req_d.freq    = req.req_freq;
          req_d.vol     = req.req_vol;
          match_found_d = 1'b0;
          free_found_d  = 1'b0;
          cand_valid_d  = 1'b0;
          idx_d         = '0;
          state_d       = SCAN;
        end
      end
      SCAN: begin
        if (cur_key_hit && !match_found_q) begin
          match_found_d = 1'b1;
          match_idx_d   = idx_q;
        end
        if (!cur_busy && !free_found_q) begin
          free_found_d = 1'b1;
          free_idx_d   = idx_q;
        end
        if (cur_busy && better) begin
          cand_valid_d = 1'b1;
          cand_rel_d   = cur_rel;
          cand_idx_d   = idx_q;
          cand_age_d   = cur_age;
        end
        if (idx_q == LAST_IDX) state_d = COMMIT;
        else                   idx_d   = idx_q + IDX_W'(1);
      end
      COMMIT: begin
        if (req_q.on) begin
          if (match_found_q)     target = match_idx_q;
          else if (free_found_q) target = free_idx_q;
          else                   target = cand_idx_q;
          load_vec[target] = 1'b1;
          age_tick         = 1'b1;
          steal_d          = !match_found_q && !free_found_q;
        end else if (match_found_q) begin
          release_vec[match_idx_q] = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller registers.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      req_q         <= '0;
      match_found_q <= 1'b0;
      match_idx_q   <= '0;
      free_found_q  <= 1'b0;
      free_idx_q    <= '0;
      cand_valid_q  <= 1'b0;
      cand_rel_q    <= 1'b0;
      cand_idx_q    <= '0;
      cand_age_q    <= '0;
      steal_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      req_q         <= req_d;
      match_found_q <= match_found_d;
      match_idx_q   <= match_idx_d;
      free_found_q  <= free_found_d;
      free_idx_q    <= free_idx_d;
      cand_valid_q  <= cand_valid_d;
      cand_rel_q    <= cand_rel_d;
      cand_idx_q    <= cand_idx_d;
      cand_age_q    <= cand_age_d;
      steal_pulse_q <= steal_d;
    end
  end

  assign req.req_ready = (state_q == IDLE);
  assign steal_pulse   = steal_pulse_q;

  // Voice slots and packed output mapping.
  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_slot
    voice_slot #(
      .RELEASE_CYCLES(RELEASE_CYCLES),
      .AGE_BITS      (AGE_BITS)
    ) u_slot (
      .clk       (mclk),
      .rst_n     (rst_n),
      .load_i    (load_vec[i]),
      .release_i (release_vec[i]),
      .age_tick_i(age_tick),
      .key_i     (req_q.key),
      .freq_i    (req_q.freq),
      .vol_i     (req_q.vol),
      .state_o   (slot_state[i]),
      .key_o     (slot_key[i]),
      .freq_o    (slot_freq[i]),
      .vol_o     (slot_vol[i]),
      .age_o     (slot_age[i])
    );
    assign voice_freq[i*FREQ_RES_BITS +: FREQ_RES_BITS] = slot_freq[i];
    assign voice_vol[i*VOLUME_BITS +: VOLUME_BITS]      = slot_vol[i];
    assign voice_gate[i] = (slot_state[i] == ACTIVE);
    assign voice_busy[i] = (slot_state[i] != FREE);
  end

`ifdef VOICE_ALLOCATOR_STATS_EN
  logic [CNT_BITS-1:0] steal_cnt_q, drop_cnt_q;
  logic                drop_c;

  assign drop_c = (state_q == COMMIT) && !req_q.on && !match_found_q;

  // Saturating steal and dropped-note-off counters.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      steal_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (steal_d) steal_cnt_q <= sat_inc(steal_cnt_q);
      if (drop_c)  drop_cnt_q  <= sat_inc(drop_cnt_q);
    end
  end

  assign steal_count = steal_cnt_q;
  assign drop_count  = drop_cnt_q;
`else
  assign steal_count = '0;
  assign drop_count  = '0;
`endif

endmodule

// File: tb/tb_voice_allocator.sv
// Directed self-checking bench for voice_allocator (4 voices, 16-cycle release).
module tb_voice_allocator;
  import voice_alloc_pkg::*;

  localparam int unsigned NV = 4;

  logic        mclk = 1'b0;
  logic        rst_n;
  logic [31:0] voice_freq, voice_vol;
  logic [3:0]  voice_gate, voice_busy;
  logic        steal_pulse;
  logic [15:0] steal_count, drop_count;
  int          checks = 0;
  int          failures = 0;

  voice_allocator_if ifc ();

  voice_allocator #(
    .NUM_VOICES    (NV),
    .RELEASE_CYCLES(16),
    .AGE_BITS      (8)
  ) dut (
    .mclk       (mclk),
    .rst_n      (rst_n),
    .req        (ifc),
    .voice_freq (voice_freq),
    .voice_vol  (voice_vol),
    .voice_gate (voice_gate),
    .voice_busy (voice_busy),
    .steal_pulse(steal_pulse),
    .steal_count(steal_count),
    .drop_count (drop_count)
  );

  always #5 mclk = ~mclk;

`ifdef VOICE_ALLOCATOR_STATS_EN
  localparam logic [15:0] ONE_IF_STATS = 16'd1;
`else
  localparam logic [15:0] ONE_IF_STATS = 16'd0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] fq(input int i);
    logic [31:0] v;
    v = voice_freq;
    return v[i*8 +: 8];
  endfunction

  function automatic logic [7:0] vl(input int i);
    logic [31:0] v;
    v = voice_vol;
    return v[i*8 +: 8];
  endfunction

  task automatic do_reset();
    @(negedge mclk);
    rst_n = 1'b0;
    repeat (2) @(negedge mclk);
    rst_n = 1'b1;
  endtask

  // Waits (bounded) for ready, then presents one request; returns just after accept edge.
  task automatic accept(input logic on, input logic [6:0] key, input logic [7:0] f, input logic [7:0] v);
    int n = 0;
    @(negedge mclk);
    while (!ifc.req_ready && n < 50) begin
      @(negedge mclk);
      n++;
    end
    chk("ready_wait", 32'(ifc.req_ready), 32'd1);
    ifc.req_valid = 1'b1;
    ifc.req_on    = on;
    ifc.req_key   = key;
    ifc.req_freq  = f;
    ifc.req_vol   = v;
    @(posedge mclk);
    #1 ifc.req_valid = 1'b0;
  endtask

  // Full request: sample just after the COMMIT edge T+NV+1.
  task automatic send(input logic on, input logic [6:0] key, input logic [7:0] f, input logic [7:0] v);
    accept(on, key, f, v);
    repeat (NV + 1) @(posedge mclk);
    #1;
  endtask

  initial begin
    rst_n         = 1'b1;
    ifc.req_valid = 1'b0;
    ifc.req_on    = 1'b0;
    ifc.req_key   = '0;
    ifc.req_freq  = '0;
    ifc.req_vol   = '0;
    do_reset();
    #1;
    chk("rst_busy",  32'(voice_busy), 32'h0);
    chk("rst_gate",  32'(voice_gate), 32'h0);
    chk("rst_freq",  voice_freq, 32'h0);
    chk("rst_vol",   voice_vol, 32'h0);
    chk("rst_steal", 32'(steal_pulse), 32'h0);
    chk("rst_ready", 32'(ifc.req_ready), 32'h1);
    chk("rst_scnt",  32'(steal_count), 32'h0);
    chk("rst_dcnt",  32'(drop_count), 32'h0);

    // 1: single note-on, latency and ready timing
    accept(1'b1, 7'd60, 8'h20, 8'h40);
    repeat (NV) @(posedge mclk);
    #1;
    chk("t1_ready_busy", 32'(ifc.req_ready), 32'h0);
    chk("t1_gate_early", 32'(voice_gate), 32'h0);
    @(posedge mclk);
    #1;
    chk("t1_gate",  32'(voice_gate), 32'h1);
    chk("t1_freq0", 32'(fq(0)), 32'h20);
    chk("t1_vol0",  32'(vl(0)), 32'h40);
    chk("t1_ready", 32'(ifc.req_ready), 32'h1);

    // 2: four voices, note-off key 61 and release expiry
    do_reset();
    for (int k = 0; k < 4; k++) send(1'b1, 7'(60 + k), 8'(8'h10 + k), 8'(8'h50 + k));
    chk("t2_gate_all", 32'(voice_gate), 32'hF);
    send(1'b0, 7'd61, 8'h00, 8'h00);
    chk("t2_gate_off", 32'(voice_gate), 32'hD);
    chk("t2_busy_off", 32'(voice_busy), 32'hF);
    chk("t2_vol1_hold", 32'(vl(1)), 32'h51);
    repeat (15) @(posedge mclk);
    #1;
    chk("t2_busy_15", 32'(voice_busy), 32'hF);
    @(posedge mclk);
    #1;
    chk("t2_busy_16", 32'(voice_busy), 32'hD);
    chk("t2_vol1_0",  32'(vl(1)), 32'h00);
    chk("t2_freq1",   32'(fq(1)), 32'h11);

    // 3: fifth note-on steals oldest voice 0
    do_reset();
    for (int k = 0; k < 4; k++) send(1'b1, 7'(60 + k), 8'(8'h10 + k), 8'(8'h50 + k));
    chk("t3_steal_pre", 32'(steal_pulse), 32'h0);
    send(1'b1, 7'd64, 8'h14, 8'h54);
    chk("t3_steal",  32'(steal_pulse), 32'h1);
    chk("t3_freq0",  32'(fq(0)), 32'h14);
    chk("t3_freq1",  32'(fq(1)), 32'h11);
    chk("t3_gate",   32'(voice_gate), 32'hF);
    chk("t3_scnt",   32'(steal_count), 32'(ONE_IF_STATS));
    @(posedge mclk);
    #1;
    chk("t3_steal_1cyc", 32'(steal_pulse), 32'h0);
    send(1'b0, 7'd64, 8'h00, 8'h00);
    chk("t3_key64_v0", 32'(voice_gate), 32'hE);

    // 4: releasing voice preferred over oldest active
    do_reset();
    for (int k = 0; k < 4; k++) send(1'b1, 7'(60 + k), 8'(8'h10 + k), 8'(8'h50 + k));
    send(1'b0, 7'd62, 8'h00, 8'h00);
    chk("t4_gate_rel", 32'(voice_gate), 32'hB);
    send(1'b1, 7'd70, 8'h70, 8'h77);
    chk("t4_freq2", 32'(fq(2)), 32'h70);
    chk("t4_freq0", 32'(fq(0)), 32'h10);
    chk("t4_gate",  32'(voice_gate), 32'hF);
    chk("t4_steal", 32'(steal_pulse), 32'h1);

    // 5: retrigger of a releasing voice
    do_reset();
    send(1'b1, 7'd60, 8'h10, 8'h50);
    send(1'b1, 7'd61, 8'h11, 8'h51);
    send(1'b0, 7'd60, 8'h00, 8'h00);
    chk("t5_gate_rel", 32'(voice_gate), 32'h2);
    send(1'b1, 7'd60, 8'h30, 8'h33);
    chk("t5_gate",  32'(voice_gate), 32'h3);
    chk("t5_busy",  32'(voice_busy), 32'h3);
    chk("t5_freq0", 32'(fq(0)), 32'h30);
    chk("t5_vol0",  32'(vl(0)), 32'h33);
    chk("t5_freq1", 32'(fq(1)), 32'h11);
    chk("t5_steal", 32'(steal_pulse), 32'h0);
    repeat (20) @(posedge mclk);
    #1;
    chk("t5_busy_held", 32'(voice_busy), 32'h3);

    // 6: unmatched note-off, then reset mid-SCAN
    do_reset();
    send(1'b1, 7'd60, 8'h20, 8'h40);
    send(1'b0, 7'd99, 8'h00, 8'h00);
    chk("t6_gate", 32'(voice_gate), 32'h1);
    chk("t6_busy", 32'(voice_busy), 32'h1);
    chk("t6_freq", voice_freq, 32'h20);
    chk("t6_vol",  voice_vol, 32'h40);
    chk("t6_dcnt", 32'(drop_count), 32'(ONE_IF_STATS));
    accept(1'b1, 7'd61, 8'h21, 8'h41);
    @(posedge mclk);
    @(negedge mclk);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(voice_busy), 32'h0);
    chk("t6_rst_freq", voice_freq, 32'h0);
    @(negedge mclk);
    rst_n = 1'b1;
    #1;
    chk("t6_rst_ready", 32'(ifc.req_ready), 32'h1);
    chk("t6_rst_vol",   voice_vol, 32'h0);
    chk("t6_rst_dcnt",  32'(drop_count), 32'h0);
    repeat (NV + 2) @(posedge mclk);
    #1;
    chk("t6_aborted", 32'(voice_gate), 32'h0);
    send(1'b1, 7'd65, 8'h25, 8'h45);
    chk("t6_after_gate", 32'(voice_gate), 32'h1);
    chk("t6_after_freq", 32'(fq(0)), 32'h25);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
